// File: rtl/booth_pp_bank.sv
// Partial-product bank for a radix-4 Booth multiplier: collects NUM_PP shifted,
// sign-extended rows serially, keeps a running modular sum, then hands the bank downstream.
module booth_pp_bank #(
    parameter  int WIDTH  = 8,
    localparam int NUM_PP = WIDTH / 2,
    localparam int OUT_W  = 2 * WIDTH,
    localparam int IDX_W  = (NUM_PP > 1) ? $clog2(NUM_PP) : 1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH:0]          data_in,
    output logic [IDX_W-1:0]        row_idx,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NUM_PP*OUT_W-1:0] out_pp,
    output logic [OUT_W-1:0]        out_sum
);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NUM_PP - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [OUT_W-1:0] r_rows [NUM_PP];
    logic [IDX_W-1:0] r_row_idx;
    logic [OUT_W-1:0] r_sum;

    logic             w_in_fire;
    logic             w_out_fire;
    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_row;

    // Handshake outputs decode the state register only, so no path from in_valid/out_ready.
    assign in_ready   = (r_state == S_FILL);
    assign out_valid  = (r_state == S_FULL);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    assign w_sext = {{(OUT_W - WIDTH - 1){data_in[WIDTH]}}, data_in};
    assign w_row  = w_sext << {r_row_idx, 1'b0};

    assign row_idx = r_row_idx;
    assign out_sum = r_sum;

    for (genvar g = 0; g < NUM_PP; g++) begin : g_pack
        assign out_pp[g*OUT_W +: OUT_W] = r_rows[g];
    end

    // NOTE: state and data registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: default assigned first so no path through this block can infer a latch.
    always_comb begin
        w_state_next = r_state;
        if (flush) begin
            w_state_next = S_FILL;
        end else begin
            case (r_state)
                S_FILL:  if (w_in_fire && (r_row_idx == LAST_ROW)) w_state_next = S_FULL;
                S_FULL:  if (out_ready) w_state_next = S_FILL;
                default: w_state_next = S_FILL;
            endcase
        end
    end

    // NOTE: the row array is reset because unwritten rows must read as zero downstream.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < NUM_PP; i++) r_rows[i] <= '0;
            r_row_idx <= '0;
            r_sum     <= '0;
        end else if (flush || w_out_fire) begin
            // flush outranks a same-edge accept: the beat is dropped.
            for (int i = 0; i < NUM_PP; i++) r_rows[i] <= '0;
            r_row_idx <= '0;
            r_sum     <= '0;
        end else if (w_in_fire) begin
            r_rows[r_row_idx] <= w_row;
            r_sum             <= r_sum + w_row;
            r_row_idx         <= (r_row_idx == LAST_ROW) ? '0 : r_row_idx + 1'b1;
        end
    end

endmodule

// File: doc/booth_pp_bank.md
# booth_pp_bank

Parametrised partial-product bank for the pipelined radix-4 Booth multiplier. It accepts WIDTH/2 Booth partial products serially, one per valid/ready beat. Each row is sign-extended, shifted left by 2×row index and stored; a running modular sum is kept alongside. Once every row is loaded, the full bank and the product are presented downstream under a valid/ready handshake. It sits between the Booth encoder/partial-product generator and the final adder/product register stage. It replaces the fixed per-row 8-bit partial-product registers.

## Interface
- WIDTH, 8 — multiplicand/multiplier width; even, ≥ 4
- NUM_PP, WIDTH/2 — derived, not overridable; number of partial-product rows
- OUT_W, 2*WIDTH — derived; row and sum width
- IDX_W, clog2(NUM_PP) (min 1) — derived; row counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- clr  in  1  reset; asynchronous, active-high; clears all state
- flush  in  1  synchronous abort; discards partial bank, returns to FILL
- in_valid  in  1  data_in holds a partial product
- in_ready  out  1  bank can accept a row this cycle
- data_in  in  WIDTH+1  two's-complement partial product (±0, ±A, ±2A)
- row_idx  out  IDX_W  index of the next row to be written
- out_valid  out  1  bank complete; out_pp/out_sum valid
- out_ready  in  1  downstream consumes the bank
- out_pp  out  NUM_PP*OUT_W  row i at bits [i*OUT_W +: OUT_W]
- out_sum  out  OUT_W  modular sum of all accepted rows (the product)

## Operation
- States: FILL, FULL. Reset state is FILL.
- Reset values: in_ready=1, out_valid=0, row_idx=0, out_pp=0, out_sum=0.
- In FILL, in_ready=1 and out_valid=0. In FULL, in_ready=0 and out_valid=1.
- Accept: in_valid && in_ready at a rising edge.
  - Row slot row_idx is written with sext(data_in, OUT_W) << (2*row_idx), truncated to OUT_W; low 2*row_idx bits are 0.
  - Example for WIDTH=8, row 3: {data_in[8], data_in, 6'b0}.
- On accept, out_sum <= out_sum + stored row value, modulo 2^OUT_W; overflow is discarded.
- row_idx increments on each accept. Accepting row NUM_PP-1 moves to FULL, and row_idx wraps to 0.
- FULL holds out_pp and out_sum stable until out_valid && out_ready.
- At that edge: all rows and out_sum clear to 0, row_idx=0, and the state returns to FILL.
- Rows not yet written read as 0.
- flush=1 at an edge (any state): same clearing as the out handshake, and state goes to FILL.
  - flush has priority over a simultaneous accept or out handshake; the data beat is dropped.
- clr asserted at any time, including mid-fill or in FULL: immediate return to reset values, independent of clk.
- in_valid while in_ready=0 is ignored; no data is lost internally and upstream must hold the beat.
- out_ready while out_valid=0 has no effect.

## Timing
- in_ready and out_valid are registered state decodes, with no combinational path from in_valid or out_ready.
- One row per cycle at full rate.
- out_valid rises the cycle after the edge that accepts row NUM_PP-1.
- Minimum bank period: NUM_PP fill cycles + 1 FULL cycle. There is one bubble: in_ready returns the cycle after the out handshake, not the same cycle.
- out_sum is valid in the same cycle that out_valid is high. It is also observable mid-fill as a partial sum, one cycle after each accept.
- Deassertion of clr: the first accept can occur at the first rising edge after release.

## Test plan
- WIDTH=8, 3×5: feed rows 9'h003, 9'h003, 9'h000, 9'h000 back-to-back with out_ready=0.
  - Expect out_valid after the 4th accept, out_pp rows 16'h0003, 16'h000C, 0, 0, and out_sum=16'h000F.
  - Expect in_ready=0 while FULL.
- WIDTH=8, 3×(−1): rows 9'h1FD, 0, 0, 0 → out_sum=16'hFFFD.
  - Row 3 sign check: data_in=9'h1FF at row 3 gives stored row 16'hFFC0.
- Backpressure: hold out_ready=0 for 5 cycles in FULL → outputs stable and in_valid ignored. Then raise out_ready for 1 cycle → next cycle row_idx=0, out_sum=0, in_ready=1.
- Gapped input: in_valid toggled 1/0 across 8 cycles → out_valid only after the 4th accept, and sum identical to the back-to-back case.
- flush after 2 accepts, with in_valid=1 in the same cycle → row_idx=0, sum=0, the beat is not stored. A fresh 4-row fill then produces the correct product.
- clr pulsed asynchronously mid-fill (row_idx=2) and separately during FULL → all outputs at reset values before the next clk edge.
- WIDTH=16 (NUM_PP=8): random signed A,B; the bench generates Booth rows → out_sum == A*B mod 2^32 for 200 vectors.
